// File: rtl/elm_weight_loader.sv
// Weight/bias loader: turns a flat word stream into per-neuron weight and bias strobes for one layer.
// Optional LOADER_CHECKSUM_EN adds a modular sum of every accepted stream word.
module elm_weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WEIGHT = 128,
  parameter int NUM_NEURON = 30,
  parameter int CFG_WIDTH  = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CFG_WIDTH-1:0]  layer_sel,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  biasValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic [CFG_WIDTH-1:0]  config_layer_num,
  output logic [CFG_WIDTH-1:0]  config_neuron_num,
  output logic                  busy,
  output logic                  done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int WCNT_W = $clog2(NUM_WEIGHT + 1);
  localparam logic [WCNT_W-1:0]    WLAST = WCNT_W'(NUM_WEIGHT - 1);
  localparam logic [CFG_WIDTH-1:0] NLAST = CFG_WIDTH'(NUM_NEURON - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WEIGHT = 3'd1;
  localparam logic [2:0] S_BIAS   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              w_hs;

  assign s_ready = (r_state == S_WEIGHT) || (r_state == S_BIAS);
  assign w_hs    = s_valid & s_ready;
  assign done    = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_wcnt            <= '0;
      weightValid       <= 1'b0;
      weightValue       <= '0;
      biasValid         <= 1'b0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            config_layer_num  <= layer_sel;
            config_neuron_num <= '0;
            busy              <= 1'b1;
            r_wcnt            <= '0;
            r_state           <= S_WEIGHT;
          end
        end
        S_WEIGHT: begin
          if (w_hs) begin
            weightValid <= 1'b1;
            weightValue <= s_data;
            if (r_wcnt == WLAST) begin
              r_wcnt  <= '0;
              r_state <= S_BIAS;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        S_BIAS: begin
          if (w_hs) begin
            biasValid <= 1'b1;
            biasValue <= s_data;
            r_state   <= S_NEXT;
          end
        end
        // One dead cycle keeps the neuron index stable under the bias strobe.
        S_NEXT: begin
          if (config_neuron_num == NLAST) begin
            r_state <= S_DONE;
          end else begin
            config_neuron_num <= config_neuron_num + 1'b1;
            r_state           <= S_WEIGHT;
          end
        end
        S_DONE: begin
          busy             <= 1'b0;
          config_layer_num <= '0;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
  assign checksum = r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_elm_weight_loader.sv
// Directed bench for elm_weight_loader with a strobe scoreboard (NUM_WEIGHT=4, NUM_NEURON=2).
// Define LOADER_CHECKSUM_EN for both files to also check the checksum output.
module tb_elm_weight_loader;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int NN = 2;
  localparam int CW = 33;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] layer_sel = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, weightValid, biasValid, busy, done;
  logic [DW-1:0] weightValue, biasValue;
  logic [CW-1:0] config_layer_num, config_neuron_num;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  elm_weight_loader #(
    .DATA_WIDTH(DW), .NUM_WEIGHT(NW), .NUM_NEURON(NN), .CFG_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weightValid(weightValid), .weightValue(weightValue),
    .biasValid(biasValid), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_bias;
    logic [DW-1:0] val;
    logic [CW-1:0] neuron;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            n_done = 0;
  int            m_idx = 0;
  logic [CW-1:0] m_layer = '0;
  logic          prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (weightValid || biasValid) begin
        check("single_strobe", 64'(weightValid & biasValid), 64'd0);
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("strobe_kind", 64'(biasValid), 64'(mon_e.is_bias));
          check("strobe_value", 64'(mon_e.is_bias ? biasValue : weightValue), 64'(mon_e.val));
          check("strobe_layer", 64'(config_layer_num), 64'(m_layer));
          check("strobe_neuron", 64'(config_neuron_num), 64'(mon_e.neuron));
        end
      end
      if (done) begin
        n_done++;
        check("done_one_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = done;
    end
  end

  task automatic drive_word(input logic [DW-1:0] d);
    bit got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back('{is_bias: ((m_idx % (NW + 1)) == NW), val: d,
                       neuron: CW'(m_idx / (NW + 1))});
        m_idx++;
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    check("handshake_in_budget", 64'(got), 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic do_start(input logic [CW-1:0] l);
    start     = 1'b1;
    layer_sel = l;
    m_layer   = l;
    m_idx     = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_layer", 64'(config_layer_num), 64'(l));
    check("start_neuron", 64'(config_neuron_num), 64'd0);
  endtask

  task automatic load_check(input int nd_exp, input logic [DW-1:0] last_w,
                            input logic [DW-1:0] last_b, input logic [DW-1:0] csum);
    bit seen = 1'b0;
    int cyc = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("done_latency", 64'(cyc), 64'd2);
    check("busy_at_done", 64'(busy), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("weight_hold", 64'(weightValue), 64'(last_w));
    check("bias_hold", 64'(biasValue), 64'(last_b));
`ifdef LOADER_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(csum));
`else
    if (csum == '1) check("csum_arg_unused", 64'(done), 64'd1);
`endif
    @(negedge clk);
    #1;
    check("done_low_after", 64'(done), 64'd0);
    check("busy_low_after", 64'(busy), 64'd0);
    check("layer_zero_idle", 64'(config_layer_num), 64'd0);
    check("done_count", 64'(n_done), 64'(nd_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({weightValid, biasValid, busy, done, s_ready}), 64'd0);
    check("rst_values", 64'({weightValue, biasValue}), 64'd0);
    check("rst_layer", 64'(config_layer_num), 64'd0);
    check("rst_neuron", 64'(config_neuron_num), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle: s_valid must not be accepted
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_s_ready", 64'(s_ready), 64'd0);
      check("idle_layer", 64'(config_layer_num), 64'd0);
      check("idle_no_strobe", 64'(weightValid | biasValid), 64'd0);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;

    // Continuous stream 1..10
    do_start(1);
    for (int d = 1; d <= 10; d++) drive_word(DW'(d));
    load_check(1, 16'd9, 16'd10, 16'd55);

    // s_valid toggling every other cycle
    do_start(2);
    for (int d = 1; d <= 10; d++) begin
      drive_word(DW'(d));
      if (d != 10) begin
        @(posedge clk);
        #1;
      end
    end
    load_check(2, 16'd9, 16'd10, 16'd55);

    // Start pulse mid-load is ignored
    do_start(3);
    for (int d = 1; d <= 6; d++) drive_word(DW'(d));
    start     = 1'b1;
    layer_sel = 33'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midstart_layer", 64'(config_layer_num), 64'd3);
    check("midstart_neuron", 64'(config_neuron_num), 64'd1);
    check("midstart_busy", 64'(busy), 64'd1);
    for (int d = 7; d <= 10; d++) drive_word(DW'(d));
    load_check(3, 16'd9, 16'd10, 16'd55);

    // Asynchronous reset after the third weight of neuron 1, then a clean reload
    do_start(4);
    for (int d = 1; d <= 8; d++) drive_word(DW'(d));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ctrl", 64'({weightValid, biasValid, busy, done, s_ready}), 64'd0);
    check("arst_values", 64'({weightValue, biasValue}), 64'd0);
    check("arst_layer", 64'(config_layer_num), 64'd0);
    check("arst_neuron", 64'(config_neuron_num), 64'd0);
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_start(5);
    for (int d = 101; d <= 110; d++) drive_word(DW'(d));
    load_check(4, 16'd109, 16'd110, 16'd1055);

    // All-ones words: modular checksum wraps
    do_start(6);
    for (int d = 0; d < 10; d++) drive_word(16'hFFFF);
    load_check(5, 16'hFFFF, 16'hFFFF, 16'hFFF6);

    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
